// File: rtl/sifive_scope_dcache_d_echo_capture.sv
// Passive TL-D snoop that folds each multi-beat D response into one record
// and queues records for the dcache echo scope over a valid/ready port.
//
// Ports:
//   clock, reset_n        block clock, async active-low reset
//   d_valid .. d_corrupt  snooped TL-D channel (never back-pressured)
//   enable                capture enable, sampled at each message's first beat
//   rec_valid/rec_ready   record handshake to the scope consumer
//   rec_bits              head record {[ts], source, opcode, size, echo,
//                         denied, corrupt_any}
//   drop_cnt, overflow    saturating drop count and sticky drop flag
//
// Optional: define SIFIVE_SCOPE_DECHO_TIMESTAMP_EN to prepend a 32-bit
// cycle timestamp, captured at each message's first beat, to rec_bits.

module sifive_scope_dcache_d_echo_capture #(
    parameter int SRC_W           = 4,
    parameter int ECHO_W          = 2,
    parameter int BEAT_BYTES_LOG2 = 3,
    parameter int DEPTH           = 4,
    parameter int DROP_W          = 8,
    localparam int BASE_W         = SRC_W + ECHO_W + 9,
`ifdef SIFIVE_SCOPE_DECHO_TIMESTAMP_EN
    localparam int REC_W          = BASE_W + 32
`else
    localparam int REC_W          = BASE_W
`endif
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              d_valid,
    input  logic              d_ready,
    input  logic [2:0]        d_opcode,
    input  logic [3:0]        d_size,
    input  logic [SRC_W-1:0]  d_source,
    input  logic [ECHO_W-1:0] d_echo,
    input  logic              d_denied,
    input  logic              d_corrupt,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [REC_W-1:0]  rec_bits,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              overflow,
    input  logic              enable
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [SRC_W-1:0]   h_src;
    logic [2:0]         h_op;
    logic [3:0]         h_size;
    logic [ECHO_W-1:0]  h_echo;
    logic               h_den;
    logic               corr_acc;
    logic               en_lat;

    logic               fire;
    logic               data_op;
    logic               multi;
    logic [3:0]         shamt;
    logic [CNT_W-1:0]   first_cnt;
    logic               complete;
    logic               rec_en;
    logic               push;
    logic [REC_W-1:0]   rec_new;

    logic [REC_W-1:0]   mem [DEPTH];
    logic [PW:0]        wptr;
    logic [PW:0]        rptr;
    logic               empty;
    logic               full;
    logic               do_pop;
    logic               do_push;
    logic               drop;

`ifdef SIFIVE_SCOPE_DECHO_TIMESTAMP_EN
    logic [31:0]        ts_cnt;
    logic [31:0]        ts_lat;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
        end
    end
`endif

    assign fire    = d_valid && d_ready;
    assign data_op = (d_opcode == 3'd1) || (d_opcode == 3'd5);
    assign multi   = data_op && (d_size > 4'(BEAT_BYTES_LOG2));
    assign shamt   = d_size - 4'(BEAT_BYTES_LOG2);
    // Remaining beats after the first one.
    assign first_cnt = (CNT_W'(1) << shamt) - CNT_W'(1);

    assign complete = fire &&
        ((state == IDLE) ? !multi : (cnt == CNT_W'(1)));
    assign rec_en   = (state == IDLE) ? enable : en_lat;
    assign push     = complete && rec_en;

    // Single-beat records come straight from the bus; burst records use the
    // header latched at the first beat plus this beat's corrupt.
    always_comb begin
        rec_new = '0;
        if (state == IDLE) begin
`ifdef SIFIVE_SCOPE_DECHO_TIMESTAMP_EN
            rec_new = {ts_cnt, d_source, d_opcode, d_size,
                       d_echo, d_denied, d_corrupt};
`else
            rec_new = {d_source, d_opcode, d_size,
                       d_echo, d_denied, d_corrupt};
`endif
        end else begin
`ifdef SIFIVE_SCOPE_DECHO_TIMESTAMP_EN
            rec_new = {ts_lat, h_src, h_op, h_size,
                       h_echo, h_den, corr_acc | d_corrupt};
`else
            rec_new = {h_src, h_op, h_size,
                       h_echo, h_den, corr_acc | d_corrupt};
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            h_src    <= '0;
            h_op     <= '0;
            h_size   <= '0;
            h_echo   <= '0;
            h_den    <= 1'b0;
            corr_acc <= 1'b0;
            en_lat   <= 1'b0;
`ifdef SIFIVE_SCOPE_DECHO_TIMESTAMP_EN
            ts_lat   <= '0;
`endif
        end else if (fire) begin
            unique case (state)
                IDLE: begin
                    if (multi) begin
                        state    <= BURST;
                        cnt      <= first_cnt;
                        h_src    <= d_source;
                        h_op     <= d_opcode;
                        h_size   <= d_size;
                        h_echo   <= d_echo;
                        h_den    <= d_denied;
                        corr_acc <= d_corrupt;
                        en_lat   <= enable;
`ifdef SIFIVE_SCOPE_DECHO_TIMESTAMP_EN
                        ts_lat   <= ts_cnt;
`endif
                    end
                end
                BURST: begin
                    corr_acc <= corr_acc | d_corrupt;
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Extra pointer bit separates full from empty.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[PW] != rptr[PW]) &&
                     (wptr[PW-1:0] == rptr[PW-1:0]);
    assign do_pop  = rec_valid && rec_ready;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    assign rec_valid = !empty;
    assign rec_bits  = empty ? '0 : mem[rptr[PW-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr[PW-1:0]] <= rec_new;
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sifive_scope_dcache_d_echo_capture.sv
// Scoreboard bench for sifive_scope_dcache_d_echo_capture: stimulus pushes
// expected records, a negedge monitor pops and compares on each handshake.

module tb_sifive_scope_dcache_d_echo_capture;

    localparam int BASE_W = 15;
`ifdef SIFIVE_SCOPE_DECHO_TIMESTAMP_EN
    localparam int REC_W = BASE_W + 32;
`else
    localparam int REC_W = BASE_W;
`endif

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             d_valid = 1'b0;
    logic             d_ready = 1'b0;
    logic [2:0]       d_opcode = '0;
    logic [3:0]       d_size = '0;
    logic [3:0]       d_source = '0;
    logic [1:0]       d_echo = '0;
    logic             d_denied = 1'b0;
    logic             d_corrupt = 1'b0;
    logic             rec_valid;
    logic             rec_ready = 1'b0;
    logic [REC_W-1:0] rec_bits;
    logic [7:0]       drop_cnt;
    logic             overflow;
    logic             enable = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [BASE_W-1:0] sb [$];

    always #5 clock = ~clock;

    sifive_scope_dcache_d_echo_capture dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_opcode  (d_opcode),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_echo    (d_echo),
        .d_denied  (d_denied),
        .d_corrupt (d_corrupt),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_bits  (rec_bits),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow),
        .enable    (enable)
    );

    function automatic logic [BASE_W-1:0] mk(
        input logic [3:0] s, input logic [2:0] op,
        input logic [3:0] sz, input logic [1:0] e,
        input logic dn, input logic c);
        return {s, op, sz, e, dn, c};
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic beat(input logic [2:0] op, input logic [3:0] sz,
                        input logic [3:0] s, input logic [1:0] e,
                        input logic dn, input logic c);
        d_valid  = 1'b1;
        d_ready  = 1'b1;
        d_opcode = op;
        d_size   = sz;
        d_source = s;
        d_echo   = e;
        d_denied = dn;
        d_corrupt = c;
        @(posedge clock);
        #1;
        d_valid   = 1'b0;
        d_ready   = 1'b0;
        d_corrupt = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clock);
                if (rec_valid && rec_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_rec", 32'(rec_bits[BASE_W-1:0]),
                            32'hFFFF_FFFF);
                    end else begin
                        chk("rec_bits", 32'(rec_bits[BASE_W-1:0]),
                            32'(sb.pop_front()));
                    end
                end
            end
        join_none

        #12;
        chk("rst_valid", 32'(rec_valid), 0);
        chk("rst_bits", 32'(rec_bits[BASE_W-1:0]), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_ovf", 32'(overflow), 0);
        reset_n = 1'b1;
        idle(2);

        // single-beat AccessAck, latency 1
        rec_ready = 1'b1;
        sb.push_back(mk(3, 0, 2, 2'b10, 0, 0));
        chk("pre_valid", 32'(rec_valid), 0);
        beat(0, 2, 3, 2'b10, 0, 0);
        chk("lat1_valid", 32'(rec_valid), 1);
        idle(3);

        // GrantData 8 beats, d_ready toggling, corrupt on beat 5
        sb.push_back(mk(5, 5, 6, 1, 1, 1));
        for (int i = 0; i < 16; i++) begin
            d_valid   = 1'b1;
            d_ready   = (i % 2 == 0);
            d_opcode  = 3'd5;
            d_size    = 4'd6;
            d_source  = (i == 0) ? 4'd5 : 4'd9;
            d_echo    = (i == 0) ? 2'd1 : 2'd0;
            d_denied  = (i == 0);
            d_corrupt = (i == 8);
            @(posedge clock);
            #1;
            if (i == 12) chk("burst_early", 32'(rec_valid), 0);
            if (i == 14) chk("burst_done", 32'(rec_valid), 1);
        end
        d_valid = 1'b0;
        d_ready = 1'b0;
        d_corrupt = 1'b0;
        idle(3);

        // non-data opcode with large size is one beat;
        // data opcode at size == beat size is one beat
        sb.push_back(mk(2, 0, 6, 0, 0, 0));
        beat(0, 6, 2, 0, 0, 0);
        sb.push_back(mk(8, 1, 3, 3, 0, 1));
        beat(1, 3, 8, 3, 0, 1);
        idle(4);
        chk("drained0", 32'(rec_valid), 0);

        // fill with ready low: 6 sent, 4 kept, 2 dropped
        rec_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) sb.push_back(mk(4'(i), 0, 1, 0, 0, 0));
            beat(0, 1, 4'(i), 0, 0, 0);
        end
        chk("drop_cnt2", 32'(drop_cnt), 2);
        chk("ovf_set", 32'(overflow), 1);
        chk("full_valid", 32'(rec_valid), 1);

        // push + pop at the same edge while full: no drop
        rec_ready = 1'b1;
        sb.push_back(mk(10, 4, 0, 1, 0, 0));
        beat(4, 0, 10, 1, 0, 0);
        chk("pp_drop", 32'(drop_cnt), 2);
        idle(6);
        chk("drained1", 32'(rec_valid), 0);
        chk("sb_empty1", 32'(sb.size()), 0);

        // reset during beat 3 of an 8-beat AccessAckData
        beat(1, 6, 7, 0, 0, 1);
        beat(1, 6, 7, 0, 0, 0);
        beat(1, 6, 7, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(rec_valid), 0);
        chk("mrst_bits", 32'(rec_bits[BASE_W-1:0]), 0);
        chk("mrst_drop", 32'(drop_cnt), 0);
        chk("mrst_ovf", 32'(overflow), 0);
        idle(1);
        reset_n = 1'b1;
        idle(1);
        sb.push_back(mk(7, 2, 3, 3, 1, 0));
        beat(2, 3, 7, 3, 1, 0);
        idle(3);

        // enable low at first beat of 4-beat burst: no record
        enable = 1'b0;
        beat(1, 5, 4, 0, 0, 0);
        beat(1, 5, 4, 0, 0, 0);
        enable = 1'b1;
        beat(1, 5, 4, 0, 0, 0);
        beat(1, 5, 4, 0, 0, 0);
        idle(2);
        chk("en0_norec", 32'(rec_valid), 0);
        sb.push_back(mk(6, 5, 3, 1, 0, 0));
        beat(5, 3, 6, 1, 0, 0);
        chk("en1_rec", 32'(rec_valid), 1);

        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0 && !rec_valid) break;
            idle(1);
        end
        chk("final_sb", 32'(sb.size()), 0);
        chk("final_valid", 32'(rec_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sifive_scope_dcache_d_echo_capture.md
Name: sifive_scope_dcache_d_echo_capture

Overview:
- Passive snoop stage directly upstream of the dcache TL-D echo scope interface.
- Watches the dcache TileLink D channel and folds each multi-beat response into one record: source, opcode, size, echo bits, denied, OR of corrupt across beats.
- Buffers records in a small FIFO and presents them to the scope consumer over a valid/ready port.
- Never back-pressures the D channel: records that do not fit are dropped and counted.

Parameters:
- SRC_W, 4, width of d_source.
- ECHO_W, 2, width of d_echo user/echo field.
- BEAT_BYTES_LOG2, 3, log2 of D-channel data bus bytes (8-byte beats).
- DEPTH, 4, record FIFO entries; power of two, at least 2.
- DROP_W, 8, width of saturating drop counter.

Ports:
- clock  input  1  block clock.
- reset_n  input  1  asynchronous active-low reset.
- d_valid  input  1  snooped TL-D valid.
- d_ready  input  1  snooped TL-D ready; a beat fires when d_valid and d_ready are both 1.
- d_opcode  input  3  TL-D opcode.
- d_size  input  4  TL-D log2 transfer size.
- d_source  input  SRC_W  TL-D source id.
- d_echo  input  ECHO_W  TL-D echo field.
- d_denied  input  1  TL-D denied.
- d_corrupt  input  1  TL-D corrupt.
- rec_valid  output  1  record available to scope.
- rec_ready  input  1  scope accepts record.
- rec_bits  output  SRC_W+ECHO_W+9 (+32 with option)  record, MSB to LSB: {[ts], source, opcode, size, echo, denied, corrupt_any}.
- drop_cnt  output  DROP_W  saturating count of dropped records.
- overflow  output  1  sticky, set on first drop.
- enable  input  1  capture enable, sampled per message start.

Behaviour:
- Reset (reset_n low, async): FIFO empty, rec_valid=0, rec_bits=0, drop_cnt=0, overflow=0, FSM=IDLE, beat counter=0. Reset mid-burst discards the partial record.
- Data-bearing opcodes: 1 (AccessAckData) and 5 (GrantData).
- Beat count: beats = 1 << (d_size - BEAT_BYTES_LOG2) when d_size > BEAT_BYTES_LOG2, else 1. All other opcodes are 1 beat.
- FSM states: IDLE, BURST.
  - IDLE, fire, beats==1: record complete this cycle.
  - IDLE, fire, beats>1: latch header fields (source, opcode, size, echo, denied) from the first beat; corrupt_acc=d_corrupt; counter=beats-1; go to BURST.
  - BURST, fire: corrupt_acc |= d_corrupt; counter decrements. When counter reaches 1 on a firing beat, the record completes and the FSM returns to IDLE. Header fields from later beats are ignored.
- enable is sampled only at the first beat. enable=0 there means the whole message is tracked for beat counting but no record is produced.
- Push: a completed record is written at the clock edge ending the last beat. rec_valid rises the next cycle (latency 1 from last-beat fire).
- FIFO: DEPTH entries; rec_bits is the head entry. A pop occurs on rec_valid && rec_ready.
- Simultaneous push and pop when full: allowed, no drop.
- Push when full without a pop: record dropped; drop_cnt increments and saturates at all-ones; overflow set until reset.
- Pointers wrap modulo DEPTH. Full/empty are distinguished with an extra pointer bit.
- rec_bits holds its value while rec_valid=1 && rec_ready=0.

Optional Feature:
- Macro: SIFIVE_SCOPE_DECHO_TIMESTAMP_EN.
- Defined: a 32-bit free-running cycle counter, reset to 0, wraps at 2^32. The value at the first beat of each message is captured and prepended as rec_bits MSBs.
- Undefined: counter and field absent; rec_bits width is SRC_W+ECHO_W+9.

Test Plan:
- Single-beat AccessAck (opcode 0, size 2, source 3, echo 2'b10) fires with rec_ready=1 -> rec_valid high exactly 1 cycle later; rec_bits fields = {3,0,2,2'b10,0,0}.
- GrantData size 6 (8 beats) with d_ready toggled on alternate cycles, corrupt=1 only on beat 5 -> exactly one record after the 8th firing beat; corrupt_any=1; header from beat 1.
- rec_ready=0 and 6 single-beat messages with DEPTH=4 -> 4 records retained in order; drop_cnt=2; overflow=1. Then drain with rec_ready=1 -> 4 pops in order, rec_valid low after.
- FIFO full with push and pop in the same cycle -> no drop; occupancy stays 4; order preserved.
- reset_n asserted low after beat 3 of an 8-beat AccessAckData -> all outputs 0 immediately. A new single-beat message after release yields a correct single record.
- enable=0 at the first beat of a 4-beat response, raised mid-burst -> no record. The next message is recorded normally; with the timestamp option, its ts equals the counter at its first beat.
